// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder controller.
//   - state_t : controller FSM encoding (IDLE, SHIFT, DONE), 2 bits.
//   - cnt_w() : width of the bit counter for a given operand width.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Purely combinational 1-bit full adder.
//   Ports:
//     a, b  in   addend bits
//     ci    in   carry in
//     s     out  sum bit
//     co    out  carry out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. Operands are captured on start, then one bit
//   pair per clock is pushed through a single fa_cell with the carry kept in a
//   register. The reassembled sum and final carry are published together with
//   a one-cycle done pulse and held until the next result.
//
//   Optional feature macro: SERIAL_ADD_SUB_EN
//     defined   -> 'sub' port exists; sub=1 at acceptance computes a-b
//                  (b inverted, carry-in forced to 1; cout=1 means no borrow).
//     undefined -> add-only, no 'sub' port.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   request, sampled only in IDLE
//     a, b   in   operands (WIDTH), captured on the accepting edge
//     cin    in   carry-in, captured on the accepting edge
//     sub    in   subtract select (SERIAL_ADD_SUB_EN only)
//     busy   out  high while shifting (WIDTH cycles)
//     done   out  one-cycle pulse, sum/cout valid
//     sum    out  result (WIDTH), held until the next done
//     cout   out  final carry-out, held with sum
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Only WIDTH-1 partial sum bits need storing: the last bit produced goes
  // straight into sum together with these.
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] s_full;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1; cin has no meaning in that mode.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign s_full = {fa_s, s_sr_q};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d  = s_full[WIDTH-1:1];
        carry_d = fa_co;
        if (cnt_q == LAST_BIT) begin
          // Publish on the edge that enters DONE so done and sum align.
          sum_d   = s_full;
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (WIDTH=8). Stimulus pushes the
//   hand-computed result into a queue; a negedge monitor pops it on every done
//   pulse and also checks that sum/cout hold the previous result otherwise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
  logic             sub   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
  } res_t;

  res_t exp_q[$];
  res_t last_exp = '0;
  res_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      last_exp = '0;
    end else begin
      check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: sum=%02h cout=%b with nothing expected", sum, cout);
        end else begin
          mon_e = exp_q.pop_front();
          txn++;
          $display("txn %0d: sum=%02h cout=%b expected sum=%02h cout=%b",
                   txn, sum, cout, mon_e.s, mon_e.c);
          check("sum", {24'b0, sum}, {24'b0, mon_e.s});
          check("cout", {31'b0, cout}, {31'b0, mon_e.c});
          last_exp = mon_e;
        end
      end else begin
        check("sum_hold", {24'b0, sum}, {24'b0, last_exp.s});
        check("cout_hold", {31'b0, cout}, {31'b0, last_exp.c});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from now until done is seen; -1 on timeout.
  task automatic wait_done(input string name, output int n);
    n = 0;
    repeat (40) begin
      tick();
      n++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no done within 40 cycles", name);
    n = -1;
  endtask

  // One isolated operation from IDLE; returns latency and busy-cycle count.
  task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub,
                        input logic [7:0] es, input logic ec,
                        output int lat, output int busy_n);
    a   = ia;
    b   = ib;
    cin = icin;
    sub = isub;
    exp_q.push_back({es, ec});
    start  = 1'b1;
    lat    = 0;
    busy_n = 0;
    repeat (40) begin
      tick();
      lat++;
      start = 1'b0;
      if (busy) busy_n++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no done within 40 cycles", name);
      lat = -1;
    end
    tick();
  endtask

  initial begin
    int lat;
    int bn;
    int n;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_sum", {24'b0, sum}, 32'd0);
    check("reset_cout", {31'b0, cout}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // 1. zero operands: latency and busy duration
    run_op("t1_zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, lat, bn);
    check("t1_latency", lat, 32'd9);
    check("t1_busy_cycles", bn, 32'd8);

    // 2. overflow wrap and carry into MSB
    run_op("t2_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, lat, bn);
    run_op("t2_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, lat, bn);

    // 3. carry-in ripple; result must hold through the following operation
    run_op("t3_a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, lat, bn);
    run_op("t3_next", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, lat, bn);

    // 4. start held high; operands toggled mid-SHIFT affect only the next op
    cin = 1'b0;
    a = 8'h11; b = 8'h22;
    exp_q.push_back({8'h33, 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    exp_q.push_back({8'h10, 1'b0});
    start = 1'b1;
    repeat (4) tick();
    a = 8'h80; b = 8'h80;
    wait_done("t4_first", n);
    repeat (4) tick();
    a = 8'h0F; b = 8'h01;
    wait_done("t4_second", n);
    check("t4_spacing_1", n + 4, 32'd10);
    repeat (4) tick();
    start = 1'b0;
    a = 8'h55; b = 8'hAA;
    wait_done("t4_third", n);
    check("t4_spacing_2", n + 4, 32'd10);
    tick();

    // 5. reset mid-SHIFT: everything cleared at once, no done
    a = 8'h77; b = 8'h11; cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_done", {31'b0, done}, 32'd0);
    check("t5_sum", {24'b0, sum}, 32'd0);
    check("t5_cout", {31'b0, cout}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    run_op("t5_fresh", 8'h3C, 8'h0C, 1'b1, 1'b0, 8'h49, 1'b0, lat, bn);
    check("t5_fresh_latency", lat, 32'd9);

`ifdef SERIAL_ADD_SUB_EN
    // 6. subtraction; cin ignored when sub=1
    run_op("t6_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, lat, bn);
    run_op("t6_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, lat, bn);
`endif

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
